// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Boot-time program loader for the single-cycle RV32I core. A byte stream
// arrives over a valid/ready handshake. The first two bytes carry a 16-bit
// little-endian word count. The bytes after that are packed little-endian into
// 32-bit words, and each word is written to instruction memory through a
// dedicated write port. The core is held in reset until the image is complete.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, one trailing byte must equal the XOR of all data bytes.
//   A match finishes the load. A mismatch aborts it.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   Start       one-cycle pulse that begins a load (honoured only in IDLE)
//   Byte_Valid  upstream byte valid
//   Byte_Data   upstream byte
//   Byte_Ready  loader accepts a byte this cycle
//   Mem_WE      instruction memory write enable, one-cycle pulse per word
//   Mem_Addr    word address of the write
//   Mem_WData   instruction word to write
//   Core_Reset  holds the processor in reset until the image is loaded
//   Done        image loaded, core released
//   Error       load aborted (oversize length or checksum mismatch)
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int Width     = 32,
  parameter int Depth     = 256,
  parameter int AddrWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic                 Byte_Valid,
  input  logic [7:0]           Byte_Data,
  output logic                 Byte_Ready,
  output logic                 Mem_WE,
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [Width-1:0]     Mem_WData,
  output logic                 Core_Reset,
  output logic                 Done,
  output logic                 Error
);

  // The word counter needs one extra bit so that it can count up to Depth.
  localparam int CntW = AddrWidth + 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;
`else
  // S_LAST covers the write pulse of the final word. DONE is therefore
  // entered only after that write has been issued.
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_LAST, S_DONE, S_ERR
  } state_t;
`endif

  state_t state_q, state_d;

  logic [15:0]          len_q;
  logic [1:0]           byte_idx_q;
  logic [CntW-1:0]      word_cnt_q;
  logic [23:0]          word_buf_q;     // bytes 0..2 of the word being built
  logic                 we_q;
  logic [AddrWidth-1:0] addr_q;
  logic [Width-1:0]     wdata_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum_q;
`endif

  logic        xfer;
  logic        word_done;
  logic        last_word;
  logic [15:0] len_full;
  logic        len_too_big;

  assign xfer        = Byte_Valid && Byte_Ready;
  assign word_done   = (state_q == S_DATA) && xfer && (byte_idx_q == 2'd3);
  assign len_full    = {Byte_Data, len_q[7:0]};
  assign len_too_big = {1'b0, len_full} > 17'(Depth);
  // True while the word currently being assembled is the final word (length-1).
  assign last_word   = (17'(word_cnt_q) + 17'd1) == {1'b0, len_q};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Start) state_d = S_LEN_LO;
      S_LEN_LO: if (xfer)  state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if (len_too_big) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_LAST;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) state_d = (Byte_Data == csum_q) ? S_DONE : S_ERR;
`else
      S_LAST: state_d = S_DONE;
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Byte_Ready = 1'b0;
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA: Byte_Ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:                     Byte_Ready = 1'b1;
`endif
      default:                    Byte_Ready = 1'b0;
    endcase
    Done       = (state_q == S_DONE);
    Error      = (state_q == S_ERR);
    Core_Reset = (state_q != S_DONE);
    Mem_WE     = we_q;
    Mem_Addr   = addr_q;
    Mem_WData  = wdata_q;
  end

  // Datapath: length capture, word assembly and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q      <= '0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
      word_buf_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      we_q <= word_done;
      if (state_q == S_LEN_LO && xfer) len_q[7:0]  <= Byte_Data;
      if (state_q == S_LEN_HI && xfer) len_q[15:8] <= Byte_Data;
      if (state_q == S_DATA && xfer) begin
        byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= csum_q ^ Byte_Data;
`endif
        case (byte_idx_q)
          2'd0: word_buf_q[7:0]   <= Byte_Data;
          2'd1: word_buf_q[15:8]  <= Byte_Data;
          2'd2: word_buf_q[23:16] <= Byte_Data;
          default: begin
            // The fourth byte completes the word. The write port presents the
            // word next cycle at the address held by the pre-increment counter.
            wdata_q    <= {Byte_Data, word_buf_q};
            addr_q     <= word_cnt_q[AddrWidth-1:0];
            word_cnt_q <= word_cnt_q + 1'b1;
          end
        endcase
      end
    end
  end

endmodule
